// File: rtl/data_mem_responder.sv
// Word-addressed data memory with valid/ready request and response channels
// and a fixed accept-to-response latency.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nx;
    logic [CW-1:0] count;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  l_we;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [DATA_WIDTH-1:0] l_wdata;
    logic [NB-1:0]         l_wstrb;

    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic [NB-1:0]         c_wstrb;
    logic [IW-1:0]         idx;
    logic                  accept, done, commit, bad;

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign done      = rsp_valid && rsp_ready;

    // With LATENCY=1 the commit happens on the accept edge, before latching.
    always_comb begin
        if (state == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end else begin
            c_we    = l_we;
            c_addr  = l_addr;
            c_wdata = l_wdata;
            c_wstrb = l_wstrb;
        end
    end

    assign idx = c_addr[IW+1:2];
    assign bad = (c_addr[1:0] != 2'b00) || ({1'b0, c_addr} >= LIMIT);

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count == '0) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end
            end
            RESP: begin
                if (done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            l_we      <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= '0;
            l_wstrb   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                count   <= CW'(LATENCY - 1);
                l_we    <= req_we;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_wstrb <= req_wstrb;
            end else if (state == WAIT && count != '0) begin
                count <= count - 1'b1;
            end
            if (commit) begin
                rsp_err   <= bad;
                rsp_rdata <= (c_we || bad) ? '0 : mem[idx];
            end
        end
    end

    // Storage has no reset; only enabled lanes of in-range stores are written.
    always_ff @(posedge clk) begin
        if (!rst && commit && c_we && !bad) begin
            for (int i = 0; i < NB; i++) begin
                if (c_wstrb[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at default parameters
// (LATENCY=2, DEPTH_WORDS=1024).
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction; rsp_ready held low for 'hold' cycles once rsp_valid rises.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input int hold, input logic [31:0] exp_rd,
                       input logic exp_err);
        int lat;
        int w;
        logic [31:0] rd0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        rsp_ready = 1'b0;
        w = 0;
        while (!req_ready && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'd2);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        rd0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h10;
            req_wdata = 32'h0;
            req_wstrb = 4'hF;
            step();
            chk({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, rsp_rdata, rd0);
            chk({tag, "_hold_rready"}, {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_done"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [8:0] pat;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

        txn("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        txn("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
        txn("st_lane1", 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, 32'h0, 1'b0);
        txn("ld_lane1", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADAAEF, 1'b0);

        txn("ld_stall", 1'b0, 32'h10, 32'h0, 4'h0, 3, 32'hDEADAAEF, 1'b0);
        txn("ld_after_stall", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADAAEF, 1'b0);

        txn("st_misal", 1'b1, 32'h12, 32'h12345678, 4'hF, 0, 32'h0, 1'b1);
        txn("ld_after_misal", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADAAEF, 1'b0);
        txn("ld_oor", 1'b0, 32'h1000, 32'h0, 4'h0, 0, 32'h0, 1'b1);
        txn("st_oor", 1'b1, 32'h1010, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
        txn("ld_no_alias", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADAAEF, 1'b0);
        txn("st_last", 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0);
        txn("ld_last", 1'b0, 32'hFFC, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0);
        txn("st_nostrb", 1'b1, 32'h10, 32'h01234567, 4'h0, 0, 32'h0, 1'b0);
        txn("ld_nostrb", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADAAEF, 1'b0);

        txn("st_prior", 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, 0, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h11111111;
        req_wstrb = 4'hF;
        chk("rst_mid_acc", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_norsp", {31'b0, rsp_valid}, 32'd0);
            step();
        end
        rsp_ready = 1'b0;
        txn("ld_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h5A5A5A5A, 1'b0);

        pat = 9'b100010001;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("b2b_req_ready", {31'b0, req_ready}, {31'b0, pat[8-i]});
            if (i == 3 || i == 7) chk("b2b_rdata", rsp_rdata, 32'hDEADAAEF);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
